// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: word width, commit encodings,
// fetch FSM states and the default instruction memory depth.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int unsigned IMEM_DEPTH_DEFAULT = 32'd256;

  typedef enum logic [1:0] {
    COMMIT_SEQ    = 2'd0,
    COMMIT_BRANCH = 2'd1,
    COMMIT_JUMP   = 2'd2,
    COMMIT_JR     = 2'd3
  } commit_kind_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_VALID   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HALT    = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (sequential, taken branch, jump, jump-register)
// with an instruction-memory range check on the result.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic [WORD_W-1:0] instr_pc,
  input  logic [1:0]        commit_kind,
  input  logic [25:0]       commit_imm,
  input  logic [WORD_W-1:0] commit_reg,
  output logic [WORD_W-1:0] next_pc,
  output logic              out_of_range
);

  logic [WORD_W-1:0] seq_pc_s;

  // Select the target by commit kind; all arithmetic wraps at 2^32.
  always_comb begin
    seq_pc_s = instr_pc + 32'd1;
    next_pc  = seq_pc_s;
    case (commit_kind_e'(commit_kind))
      COMMIT_SEQ:    next_pc = seq_pc_s;
      COMMIT_BRANCH: next_pc = seq_pc_s + {{16{commit_imm[15]}}, commit_imm[15:0]};
      COMMIT_JUMP:   next_pc = {seq_pc_s[31:26], commit_imm};
      COMMIT_JR:     next_pc = commit_reg;
      default:       next_pc = seq_pc_s;
    endcase
    out_of_range = (next_pc >= WORD_W'(IMEM_DEPTH));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches from 1-cycle-latency instruction memory,
// hands instructions to decode and advances on commit. Option: FETCH_PERF_CNT_EN.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned       IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter logic [WORD_W-1:0] RESET_PC   = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              commit_valid,
  input  logic [1:0]        commit_kind,
  input  logic [25:0]       commit_imm,
  input  logic [WORD_W-1:0] commit_reg,
`ifdef FETCH_PERF_CNT_EN
  output logic [WORD_W-1:0] fetch_count,
`endif
  input  logic              halt_req,
  output logic              halted,
  output logic              fetch_fault
);

  fetch_state_e      state_r, state_next_s;
  logic [WORD_W-1:0] pc_r, instr_out_r, instr_pc_r, next_pc_s;
  logic              instr_valid_r, halted_r, fault_r, halt_pend_r;
  logic              oor_s, commit_take_s;

  next_pc_calc #(.IMEM_DEPTH(IMEM_DEPTH)) u_next_pc_calc (
    .instr_pc     (instr_pc_r),
    .commit_kind  (commit_kind),
    .commit_imm   (commit_imm),
    .commit_reg   (commit_reg),
    .next_pc      (next_pc_s),
    .out_of_range (oor_s)
  );

  assign commit_take_s = (state_r == ST_EXEC) && commit_valid;

  // Next-state logic of the fetch FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH:   state_next_s = (halt_req || halt_pend_r) ? ST_HALT : ST_CAPTURE;
      ST_CAPTURE: state_next_s = ST_VALID;
      ST_VALID:   state_next_s = instr_ready ? ST_EXEC : ST_VALID;
      ST_EXEC: begin
        if (commit_valid) begin
          state_next_s = oor_s ? ST_HALT : ST_FETCH;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_HALT:    state_next_s = ST_HALT;
      default:    state_next_s = ST_FETCH;
    endcase
  end

  // State register and datapath registers; outputs are registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      instr_out_r   <= 32'd0;
      instr_pc_r    <= 32'd0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
      halt_pend_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      instr_valid_r <= (state_next_s == ST_VALID);
      halted_r      <= (state_next_s == ST_HALT);
      if (state_r == ST_CAPTURE) begin
        instr_out_r <= instruction;
        instr_pc_r  <= pc_r;
      end
      if (commit_take_s && !oor_s) begin
        pc_r <= next_pc_s;
      end
      if (commit_take_s && oor_s) begin
        fault_r <= 1'b1;
      end
      // A halt request coinciding with a commit is deferred to the next fetch.
      if (commit_take_s && halt_req && !oor_s) begin
        halt_pend_r <= 1'b1;
      end else if (state_r == ST_FETCH) begin
        halt_pend_r <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] fetch_count_r;

  // Count accepted handshakes; frozen once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_r <= 32'd0;
    end else if (instr_valid_r && instr_ready && (state_r != ST_HALT)) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end
  end

  assign fetch_count = fetch_count_r;
`endif

  assign pc          = pc_r;
  assign instr_out   = instr_out_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;
  assign fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: bench-side instruction memory, a
// transaction-level PC model and a per-cycle compare process.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc, instruction, instr_out, instr_pc, commit_reg;
  logic        instr_valid, instr_ready, commit_valid, halt_req, halted, fetch_fault;
  logic [1:0]  commit_kind;
  logic [25:0] commit_imm;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_sequencer #(.IMEM_DEPTH(256), .RESET_PC(32'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .instruction  (instruction),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .commit_valid (commit_valid),
    .commit_kind  (commit_kind),
    .commit_imm   (commit_imm),
    .commit_reg   (commit_reg),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count  (fetch_count),
`endif
    .halt_req     (halt_req),
    .halted       (halted),
    .fetch_fault  (fetch_fault)
  );

  logic [31:0] mem [0:255];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_accept = 0;
  logic [31:0] exp_pc = 32'd0;
  logic        exp_fault = 1'b0;
  logic        chk_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) instruction <= mem[pc[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the next-PC rules in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] ipc, input int kind,
                                             input logic [25:0] imm, input logic [31:0] rg);
    int off;
    off = int'($signed(imm[15:0]));
    case (kind)
      0:       return ipc + 32'd1;
      1:       return ipc + 32'd1 + 32'(off);
      2:       return ((ipc + 32'd1) & 32'hFC00_0000) | {6'd0, imm};
      3:       return rg;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, exp_pc);
      check("fetch_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});
      if (instr_valid) begin
        check("instr_out", instr_out, mem[instr_pc[7:0]]);
        check("instr_pc", instr_pc, exp_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_seen", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_accept++;
    check("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic do_commit(input int kind, input logic [25:0] imm, input logic [31:0] rg);
    logic [31:0] nxt;
    commit_kind  = 2'(kind);
    commit_imm   = imm;
    commit_reg   = rg;
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    nxt = model_next(exp_pc, kind, imm, rg);
    if (nxt >= 32'd256) exp_fault = 1'b1;
    else exp_pc = nxt;
  endtask

  task automatic step(input int kind, input logic [25:0] imm, input logic [31:0] rg);
    int n;
    wait_valid(n);
    accept();
    tick();
    do_commit(kind, imm, rg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    mem[0] = 32'h8C01_0020;
    rst_n = 1'b0; instr_ready = 1'b1; commit_valid = 1'b0; commit_kind = 2'd0;
    commit_imm = 26'd0; commit_reg = 32'd0; halt_req = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // First fetch after reset release.
    rst_n = 1'b1;
    wait_valid(n);
    check("first_valid_edges", n, 32'd2);
    check("first_instr", instr_out, 32'h8C01_0020);
    check("first_instr_pc", instr_pc, 32'd0);
    accept();
    do_commit(2, 26'd4, 32'd0);
    check("jump_to_4", pc, 32'd4);

    step(1, 26'h000FFFD, 32'd0);  check("branch_back", pc, 32'd2);
    step(3, 26'd0, 32'd4);
    step(1, 26'h0000003, 32'd0);  check("branch_fwd", pc, 32'd8);
    step(3, 26'd0, 32'd4);
    step(2, 26'h0000010, 32'd0);  check("jump_abs", pc, 32'h10);
    step(3, 26'd0, 32'd4);
    step(3, 26'd0, 32'h20);       check("jr", pc, 32'h20);

    // Decode stalls for 5 cycles; a stray commit in VALID is ignored.
    wait_valid(n);
    instr_ready = 1'b0;
    held = instr_out;
    for (int i = 0; i < 5; i++) begin
      commit_valid = (i == 0); commit_kind = 2'd3; commit_reg = 32'd7;
      tick();
      commit_valid = 1'b0;
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_hold", instr_out, held);
    end
    accept();
    tick();
    do_commit(0, 26'd0, 32'd0);
    check("seq", pc, 32'h21);

    // Halt request in the same cycle as a SEQ commit.
    wait_valid(n);
    accept();
    halt_req = 1'b1;
    do_commit(0, 26'd0, 32'd0);
    halt_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("halt_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h22);

    // Asynchronous reset while in EXEC.
    rst_n = 1'b0; exp_pc = 32'd0; exp_fault = 1'b0; n_accept = 0;
    tick();
    rst_n = 1'b1;
    step(3, 26'd0, 32'h30);
    wait_valid(n);
    accept();
    tick();
    #2;
    rst_n = 1'b0; exp_pc = 32'd0; n_accept = 0;
    #1;
    check("async_pc", pc, 32'd0);
    check("async_instr_out", instr_out, 32'd0);
    check("async_instr_pc", instr_pc, 32'd0);
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("async_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_valid(n);
    check("refetch_edges", n, 32'd2);
    check("refetch_pc", instr_pc, 32'd0);

    // Out-of-range JR faults and halts; later commits are ignored.
    accept();
    do_commit(3, 26'd0, 32'd300);
    check("fault_set", {31'd0, fetch_fault}, 32'd1);
    check("fault_halted", {31'd0, halted}, 32'd1);
    check("fault_pc", pc, 32'd0);
    commit_kind = 2'd0; commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick();
    check("post_fault_pc", pc, 32'd0);
    check("post_fault_halted", {31'd0, halted}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'(n_accept));
`endif
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of instruction_memory in the non-pipelined MIPS core.
- Owns the program counter and drives it as a word index into the synchronous instruction memory, which has a 1-cycle read latency.
- Captures the returned word and hands it to decode/execute over a valid/ready handshake.
- Waits for execute to commit, then computes the next PC: sequential, taken branch, jump or jump-register.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory; a PC at or above this value is a fault.
- RESET_PC, 0, word index loaded into pc on reset.

Ports:
- clk  in  1  rising-edge clock, same clock as instruction_memory
- rst_n  in  1  asynchronous, active-low reset
- pc  out  32  word index driven to instruction_memory
- instruction  in  32  read data from instruction_memory, valid the cycle after pc is presented
- instr_out  out  32  captured instruction to decode
- instr_pc  out  32  word index of instr_out
- instr_valid  out  1  instr_out is valid
- instr_ready  in  1  decode accepts instr_out
- commit_valid  in  1  execute finished the accepted instruction (single-cycle pulse)
- commit_kind  in  2  0=SEQ, 1=BRANCH_TAKEN, 2=JUMP, 3=JR
- commit_imm  in  26  [15:0] = branch offset for BRANCH_TAKEN; [25:0] = target for JUMP
- commit_reg  in  32  target word index for JR
- halt_req  in  1  stop fetching at the next fetch boundary
- halted  out  1  sequencer stopped
- fetch_fault  out  1  sticky; set when a computed pc >= IMEM_DEPTH

Behaviour:
- Reset is asynchronous, active-low; one clock. While rst_n=0 and after it is released:
  - pc=RESET_PC, state=FETCH
  - instr_out=0, instr_pc=0, instr_valid=0, halted=0, fetch_fault=0
- States: FETCH, CAPTURE, VALID, EXEC, HALT.
- FETCH: pc held stable; instruction_memory samples it at this edge.
  - halt_req=1 -> HALT.
  - Otherwise -> CAPTURE.
- CAPTURE: instr_out<=instruction, instr_pc<=pc -> VALID.
- VALID: instr_valid=1.
  - instr_out and instr_pc are held stable until instr_ready=1 is sampled at a rising edge.
  - On that edge -> EXEC and instr_valid falls.
- EXEC: waits for commit_valid. On commit, next pc is computed as follows (32-bit, wrap modulo 2^32):
  - SEQ: instr_pc+1
  - BRANCH_TAKEN: instr_pc+1+sign_extend(commit_imm[15:0])
  - JUMP: {(instr_pc+1)[31:26], commit_imm[25:0]}
  - JR: commit_reg
- Then on that same commit edge:
  - next pc < IMEM_DEPTH: pc<=next, go to FETCH.
  - Otherwise: pc unchanged, fetch_fault<=1, go to HALT.
- HALT: halted=1; only reset exits this state.
- Latency: commit sampled at edge E -> pc updates at E -> memory reads at E+1 -> instr_valid high after E+2. Minimum 3 cycles per instruction plus execute time.
- After reset release the first instr_valid rises after the 2nd rising edge.
- commit_valid outside EXEC is ignored; so is a second commit pulse.
- halt_req is honoured only in FETCH. An instruction already in VALID or EXEC completes its handshake and commit first.
- halt_req and commit in the same EXEC cycle: the commit is taken, then HALT is entered from the following FETCH.
- Reset asserted mid-operation clears every register immediately, whatever the state.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output port fetch_count (out, 32).
  - It resets to 0 and increments on every instr_valid&&instr_ready edge, wrapping at 2^32.
  - It is frozen in HALT.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - commit_kind encodings COMMIT_SEQ/BRANCH/JUMP/JR
  - fetch state enum
  - IMEM_DEPTH default
  - WORD_W=32
- One natural sub-module: next_pc_calc. It is purely combinational and takes instr_pc, commit_kind, commit_imm and commit_reg, producing next_pc and out_of_range. It is reused later for verification models.

Test Plan:
- Reset release with RESET_PC=0, mem[0]=0x8C010020, instr_ready=1 -> instr_valid high after 2nd edge, instr_out=0x8C010020, instr_pc=0.
- Hold instr_ready=0 for 5 cycles in VALID -> instr_valid stays 1, instr_out and instr_pc unchanged; accepted on the first ready edge.
- At instr_pc=4:
  - BRANCH_TAKEN with imm=0xFFFD -> pc=2.
  - BRANCH_TAKEN with imm=0x0003 -> pc=8.
  - JUMP with imm=0x0000010 -> pc=0x10.
  - JR with commit_reg=0x20 -> pc=0x20.
- JR with commit_reg=300, IMEM_DEPTH=256 -> fetch_fault=1, halted=1, pc unchanged; further commits ignored.
- halt_req pulse during EXEC with a SEQ commit in the same cycle -> pc advances by 1, no new instr_valid, halted=1.
- rst_n low while in EXEC -> outputs return to reset values immediately, without waiting for a clock edge; refetch starts from RESET_PC after release.
